// File: rtl/sort_pkg.sv
// Shared widths, frame size and state encoding for the sorted-word output stage.
// Pure definitions; no logic, no latency.
// Backpressure is not applicable here; see output_part.
package sort_pkg;

  localparam int WORD_W    = 4;
  localparam int NUM_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  // One-hot slot select for a 2-bit word index
  function automatic logic [NUM_WORDS-1:0] slot_onehot(input logic [1:0] idx);
    slot_onehot = NUM_WORDS'(1) << idx;
  endfunction

endpackage

// File: rtl/output_part.sv
// Serialises a captured 4-word frame onto a valid/ready port with GAP idle cycles between words.
// Latency: first word valid the cycle after sort_done is sampled; all outputs registered.
// Backpressure: a presented word holds indefinitely while out_ready is low; starts while busy are dropped and flagged.
module output_part
  import sort_pkg::*;
#(
  parameter int unsigned GAP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] sorted_num0,
  input  logic [WORD_W-1:0] sorted_num1,
  input  logic [WORD_W-1:0] sorted_num2,
  input  logic [WORD_W-1:0] sorted_num3,
  input  logic              sort_done,
  input  logic              out_ready,
  output logic [NUM_WORDS-1:0] out_sel,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  // Gap counter is 4 bits wide, so GAP is limited to 0..15
  localparam logic [3:0] GAP_CNT  = 4'(GAP);
  localparam logic [1:0] LAST_IDX = 2'(NUM_WORDS - 1);

  state_t                               state_q;
  logic [1:0]                           idx_q;
  logic [1:0]                           idx_inc;
  logic [3:0]                           gap_cnt_q;
  logic [NUM_WORDS-1:0][WORD_W-1:0]     buf_q;
  logic [NUM_WORDS-1:0]                 sel_q;
  logic [WORD_W-1:0]                    data_q;
  logic                                 valid_q;
  logic                                 busy_q;
  logic                                 done_q;
  logic                                 overrun_q;

  assign idx_inc = idx_q + 2'd1;

  // Frame FSM: capture, word index, gap counter and every registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      gap_cnt_q <= 4'd0;
      buf_q     <= '0;
      sel_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A start while a frame is in flight is dropped; remember that it happened
      if (sort_done && (state_q != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (sort_done) begin
            buf_q[0] <= sorted_num0;
            buf_q[1] <= sorted_num1;
            buf_q[2] <= sorted_num2;
            buf_q[3] <= sorted_num3;
            idx_q    <= 2'd0;
            state_q  <= SEND;
            // Present word 0 straight from the inputs so it is valid next cycle
            valid_q  <= 1'b1;
            sel_q    <= slot_onehot(2'd0);
            data_q   <= sorted_num0;
            busy_q   <= 1'b1;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              sel_q   <= '0;
              data_q  <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_inc;
              if (GAP == 0) begin
                sel_q  <= slot_onehot(idx_inc);
                data_q <= buf_q[idx_inc];
              end else begin
                state_q   <= sort_pkg::GAP;
                gap_cnt_q <= GAP_CNT;
                valid_q   <= 1'b0;
                sel_q     <= '0;
                data_q    <= '0;
              end
            end
          end
        end
        sort_pkg::GAP: begin
          // Counter entered at GAP and leaves on 1, giving GAP idle cycles
          if (gap_cnt_q <= 4'd1) begin
            state_q   <= SEND;
            gap_cnt_q <= 4'd0;
            valid_q   <= 1'b1;
            sel_q     <= slot_onehot(idx_q);
            data_q    <= buf_q[idx_q];
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          sel_q   <= '0;
          data_q  <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out_sel   = sel_q;
  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/output_part.md
OUTPUT_PART -- requirements
Module: output_part

Interface
REQ-001 SHALL provide parameter GAP, default 1: idle cycles inserted between consecutive words (0 allowed, max 15).
REQ-002 SHALL provide port clk  input  1  single system clock; all state changes on posedge clk.
REQ-003 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide ports sorted_num0..sorted_num3  input  4 each  sorted words, sampled only on an accepted start.
REQ-005 SHALL provide port sort_done  input  1  start strobe; accepted only in IDLE.
REQ-006 SHALL provide port out_ready  input  1  downstream ready; a transfer occurs when out_valid and out_ready are both 1 at a posedge.
REQ-007 SHALL provide port out_sel  output  4  one-hot slot select of the presented word (bit k = slot k), 0 when not valid.
REQ-008 SHALL provide port out_data  output  4  presented word, 0 when not valid.
REQ-009 SHALL provide port out_valid  output  1  word strobe.
REQ-010 SHALL provide port busy  output  1  high in every state except IDLE.
REQ-011 SHALL provide port done  output  1  one-cycle pulse after the last transfer of a frame.
REQ-012 SHALL provide port overrun  output  1  sticky flag: sort_done seen while busy; cleared only by reset.

Function
REQ-013 SHALL implement states IDLE, SEND, GAP; all outputs registered.
REQ-014 IDLE: on posedge with sort_done=1, SHALL capture sorted_num0..3 into a 4-entry buffer, set index=0, go to SEND.
REQ-015 out_valid SHALL first be high in the cycle after the posedge that sampled sort_done (latency 1).
REQ-016 SEND: out_valid=1, out_sel=1<<index, out_data=buffer[index]; values SHALL hold stable until the transfer.
REQ-017 SEND with out_ready=0: SHALL remain in SEND, no change, indefinitely (no timeout).
REQ-018 Transfer with index<3: index+1; go to GAP with gap counter=GAP, or straight to SEND if GAP=0.
REQ-019 Transfer with index=3: go to IDLE; done=1 for exactly the next cycle; busy=0 in that same cycle.
REQ-020 GAP: out_valid/out_sel/out_data=0; counter decrements each cycle; go to SEND when it reaches 1 (GAP cycles total).
REQ-021 sort_done while busy SHALL be ignored (buffer unchanged) and SHALL set overrun.
REQ-022 sort_done in the same cycle done is high (state IDLE) SHALL be accepted normally.
REQ-023 Index SHALL be 2 bits and never wrap past 3 within a frame; frame length is always exactly 4 transfers.
REQ-024 Buffer contents SHALL be unaffected by sorted_num* changes after capture.

Reset
REQ-025 rst_n=0 SHALL immediately force state IDLE, index 0, gap counter 0, buffer 0, and out_sel=0, out_data=0, out_valid=0, busy=0, done=0, overrun=0.
REQ-026 Reset mid-frame SHALL abandon the frame with no further transfers and no done pulse.
REQ-027 After rst_n rises, the first posedge SHALL already accept sort_done.

Structure
REQ-028 Shared package sort_pkg SHALL hold WORD_W=4, NUM_WORDS=4 and the state enum {IDLE, SEND, GAP}.
REQ-029 No sub-module; FSM, index and gap counter SHALL live in one always block plus output logic.

Verification
REQ-030 Nums 3,7,9,C, GAP=1, out_ready=1 -> out_sel 1,2,4,8 with data 3,7,9,C on cycles 1,3,5,7; done on cycle 8.
REQ-031 GAP=0, out_ready=1 -> four back-to-back valid cycles, then done.
REQ-032 out_ready=0 for 5 cycles on word 2 -> out_sel=4, data=9 held for 6 cycles; word order unchanged.
REQ-033 sort_done pulsed during frame with new nums F,F,F,F -> original data delivered; overrun=1 and stays 1.
REQ-034 rst_n low after second transfer -> all outputs 0 asynchronously; no done; new frame starts cleanly afterwards.
REQ-035 sort_done asserted in the done cycle -> new frame accepted; out_valid high on the next cycle.
